udp_frame_arbiter: RTL
======================

Name: udp_frame_arbiter

Overview:
- Frame-level round-robin arbiter that shares one 32-bit AXI-Stream UDP payload channel between NUM_SRC requesters.
- Requesters are, for example, several 8-to-32 packers or application sources.
- Once a source is granted, the grant is held until that source's tlast handshake. Frames are never interleaved.
- A watchdog releases a grant held by a stalled source and flags the truncated frame.
- Sits between the payload packers and the UDP/IP TX framer.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_W, 32, stream data width.
- TIMEOUT, 1024, consecutive cycles without s_axis_tvalid from the granted source before forced release (≥2).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- src_en  in  NUM_SRC  per-source arbitration enable (configuration).
- s_axis_tdata  in  NUM_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  NUM_SRC  source valid.
- s_axis_tlast  in  NUM_SRC  source end of frame.
- s_axis_tready  out  NUM_SRC  source ready.
- m_axis_tdata  out  DATA_W  merged data.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged end of frame.
- m_axis_tready  in  1  downstream ready.
- grant_valid  out  1  high while a source owns the channel.
- grant_idx  out  $clog2(NUM_SRC)  index of the owning source.
- frame_abort  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (asynchronous, aresetn=0):
  - state=IDLE, grant_idx=0, last_grant=NUM_SRC-1, wd_cnt=0, frame_abort=0.
  - All s_axis_tready=0; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - Reset mid-frame drops the frame silently; no abort pulse is generated.
- State IDLE:
  - req = s_axis_tvalid & src_en.
  - If req≠0, pick the first set bit of req searching upward from last_grant+1, wrapping modulo NUM_SRC.
  - Register the pick into grant_idx, set grant_valid=1, and go to BUSY.
  - No data passes in IDLE. Arbitration costs exactly one cycle, so there is one bubble between consecutive frames, including frames from the same source.
- State BUSY (combinational path for granted source g=grant_idx):
  - m_axis_tdata/tvalid/tlast = source g's signals.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready bits are 0.
  - On a handshake (m_axis_tvalid & m_axis_tready) with m_axis_tlast=1: last_grant←g, grant_valid←0, go to IDLE.
- src_en is sampled only in IDLE. Deasserting src_en for the granted source mid-frame has no effect until that frame ends.
- Watchdog (BUSY only):
  - wd_cnt increments each cycle s_axis_tvalid[g]=0.
  - wd_cnt clears on any cycle with s_axis_tvalid[g]=1, including cycles stalled by m_axis_tready=0, so downstream backpressure never trips it.
  - When wd_cnt reaches TIMEOUT-1 with s_axis_tvalid[g] still 0: frame_abort=1 for exactly that cycle, last_grant←g, go to IDLE, wd_cnt←0.
  - The remainder of the aborted source frame, if it later arrives, is arbitrated as a new frame. Downstream uses frame_abort to discard the partial frame.
  - wd_cnt is forced to 0 in IDLE. The counter width is $clog2(TIMEOUT).
- Simultaneous events: tlast handshake and watchdog expiry cannot coincide, because a handshake implies valid=1. A request that rises in the same cycle the grant is released is seen in the following IDLE cycle.
- Fairness: a source that is continuously requesting waits at most NUM_SRC-1 frames.
- m_axis_tdata is 0 in IDLE; no X-propagation is allowed from unselected sources.

Decomposition:
- Package udp_arb_pkg:
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - localparam functions for index width and watchdog counter width.
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: req[NUM_SRC], last[idx].
  - Outputs: found, idx.
  - Reused by future TX schedulers.

Test Plan:
- Single source, reset released, src 0 sends 3-beat frame A0,A1,A2(tlast) with m_axis_tready=1:
  - IDLE 1 cycle, then grant_idx=0.
  - Beats out on consecutive cycles; grant_valid drops after A2.
- All 4 sources request continuously, 2-beat frames:
  - Grant order 0,1,2,3,0,1.
  - One idle cycle between frames; never two sources' beats interleaved.
- Backpressure: src 2 granted, m_axis_tready toggles 1,0,0,1 while tvalid=1 for 2000 cycles (TIMEOUT=1024):
  - No frame_abort.
  - Data held stable during stalls; s_axis_tready[2] mirrors m_axis_tready.
- Watchdog: src 1 sends 1 beat without tlast, then drops valid:
  - frame_abort pulses exactly 1024 cycles after valid drops.
  - grant_valid=0 next cycle; next pick starts at src 2.
- src_en masking: src_en=4'b1010, all sources valid:
  - Only 1 and 3 are granted, alternating.
  - Clearing src_en[1] mid-frame still completes src 1's frame.
- Async reset asserted mid-frame (between clock edges):
  - All outputs go to their reset values immediately.
  - After release, arbitration restarts with src 0 priority.

Source files
------------

// File: rtl/udp_arb_pkg.sv
// Shared types and width helpers for the UDP payload frame arbiter.
package udp_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  function automatic int wd_w(input int t);
    return (t > 2) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/udp_frame_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of req above last, wrapping.
module rr_pick
  import udp_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // Lower group (<= last) is scanned first, so any hit above last overrides it.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i] && (i <= int'(last))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(last))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/udp_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one AXI-Stream payload channel,
// with a watchdog that releases a grant held by a stalled source.
module udp_frame_arbiter
  import udp_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_SRC-1:0]          src_en,
  input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]          s_axis_tvalid,
  input  logic [NUM_SRC-1:0]          s_axis_tlast,
  output logic [NUM_SRC-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        grant_valid,
  output logic [idx_w(NUM_SRC)-1:0]   grant_idx,
  output logic                        frame_abort
);

  localparam int IDX_W = idx_w(NUM_SRC);
  localparam int WD_W  = wd_w(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   r_last_grant;
  logic [WD_W-1:0]    r_wd_cnt;

  logic [NUM_SRC-1:0] w_req;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic               w_busy;
  logic [DATA_W-1:0]  w_g_data;
  logic               w_g_valid;
  logic               w_g_last;
  logic               w_expire;

  assign w_busy = (r_state == BUSY);
  assign w_req  = s_axis_tvalid & src_en;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (w_req),
    .last  (r_last_grant),
    .found (w_found),
    .idx   (w_pick)
  );

  // Only the granted lane is routed; everything reads as zero in IDLE so
  // unselected or undriven sources can never leak onto the merged bus.
  always_comb begin
    w_g_data      = '0;
    w_g_valid     = 1'b0;
    w_g_last      = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_busy && (r_grant_idx == IDX_W'(i))) begin
        w_g_data         = s_axis_tdata[i*DATA_W +: DATA_W];
        w_g_valid        = s_axis_tvalid[i];
        w_g_last         = s_axis_tlast[i];
        s_axis_tready[i] = m_axis_tready;
      end
    end
  end

  assign w_expire      = w_busy & ~w_g_valid & (r_wd_cnt == WD_LAST);
  assign m_axis_tdata  = w_g_data;
  assign m_axis_tvalid = w_g_valid;
  assign m_axis_tlast  = w_g_last;
  assign grant_valid   = w_busy;
  assign grant_idx     = r_grant_idx;
  assign frame_abort   = w_expire;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(NUM_SRC - 1);
      r_wd_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wd_cnt <= '0;
          if (w_found) begin
            r_grant_idx <= w_pick;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          // Any valid cycle, even one stalled by downstream, proves the source alive.
          if (w_g_valid) begin
            r_wd_cnt <= '0;
            if (m_axis_tready && w_g_last) begin
              r_last_grant <= r_grant_idx;
              r_state      <= IDLE;
            end
          end else if (w_expire) begin
            r_last_grant <= r_grant_idx;
            r_wd_cnt     <= '0;
            r_state      <= IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
